operand_fetch_block: RTL and testbench
======================================

# operand_fetch_block

Register-file and operand-fetch stage at the consumer end of the write-back path. It accepts retired results (`ans_wb`) into a 16-entry × 16-bit register file and tracks which registers have writes outstanding with a scoreboard. For each instruction offered by decode it supplies registered source operands (`op_a`, `op_b`). It bypasses a result arriving from write-back in the same cycle, and stalls decode on an unresolved RAW or WAW hazard.

## Interface
- `DATA_W`, 16, register and operand width
- `ADDR_W`, 4, register address width (2^ADDR_W registers)

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `wb_en`  in  1  write-back strobe, one result per cycle
- `wb_addr`  in  ADDR_W  destination register of the retiring result
- `ans_wb`  in  DATA_W  retiring result value
- `dec_valid`  in  1  decode offers an instruction this cycle
- `rs_addr`  in  ADDR_W  source A register
- `rt_addr`  in  ADDR_W  source B register
- `rd_addr`  in  ADDR_W  destination register
- `dec_writes`  in  1  offered instruction will write `rd_addr`
- `stall`  out  1  combinational; decode must hold all inputs while high
- `op_valid`  out  1  registered; `op_a`/`op_b`/`op_rd` valid this cycle
- `op_a`  out  DATA_W  registered operand A
- `op_b`  out  DATA_W  registered operand B
- `op_rd`  out  ADDR_W  registered destination address, passed through

## Operation
- Register file: `regs[0..15]`. R0 reads as 0, ignores writes, and is never marked pending.
- Scoreboard `pend[15:0]`:
  - set bit rd on issue with `dec_writes=1`, rd≠0;
  - clear bit `wb_addr` on `wb_en=1`.
- Same-cycle issue setting X and write-back clearing X: set wins; the final state is pending.
- Write-back:
  - on `wb_en`, `regs[wb_addr] <= ans_wb` (skipped for R0);
  - unconditional, independent of `stall`;
  - `wb_en` on a non-pending register still writes and leaves `pend` clear.
- Source lookup for s ∈ {rs, rt}:
  - s=0 → 0;
  - else if `wb_en` and `wb_addr`=s → `ans_wb` (bypass, no hazard);
  - else if `pend[s]` → hazard;
  - else `regs[s]`.
- WAW: `dec_writes` with rd≠0, `pend[rd]`=1, and rd not being written back this cycle → hazard.
- `stall` = `dec_valid` & (hazard on rs | hazard on rt | WAW hazard).
- Issue condition: `dec_valid` & !`stall`.
  - On an issue edge: `op_valid<=1`; `op_a`/`op_b` take the looked-up values; `op_rd<=rd_addr`; the scoreboard updates.
  - Otherwise: `op_valid<=0`; `op_a`, `op_b`, `op_rd` hold their previous values.
- Only `dec_valid`=1 instructions update the scoreboard. A stalled instruction changes no state.

## Timing
- Reset (async assert, released synchronously by the environment):
  - all `regs` = 0, `pend` = 0;
  - `op_valid`=0, `op_a`=0, `op_b`=0, `op_rd`=0;
  - `stall`=0.
- Issue latency: 1 cycle. An instruction accepted at edge N has `op_valid`=1 and operands valid from N until N+1.
- Write-back latency: a result written at edge N is readable from the array from edge N. In the cycle before N it is visible via bypass.
- `stall` depends combinationally on the current inputs and `pend`. It deasserts in the same cycle as the `wb_en` that resolves the hazard (bypass path).
- Back-to-back issue: one instruction per cycle with no hazard.
- Reset mid-stall: the scoreboard clears, so `stall` drops immediately and the held instruction issues on the first edge after release.
- Max outstanding writes: one per register (enforced by the WAW stall).

## Test plan
- Reset check: assert `reset` asynchronously mid-cycle after activity → `op_valid`=0, `op_a`=`op_b`=0, `stall`=0, and every register reads 0 afterwards.
- Write then read:
  - `wb_en`, `wb_addr`=3, `ans_wb`=0x1111;
  - next cycle issue rs=3, rt=0 → `op_a`=0x1111, `op_b`=0x0000, `op_valid`=1 one cycle later.
- RAW stall and bypass:
  - issue rd=5 with `dec_writes`;
  - next instruction rs=5 → `stall`=1 and `op_valid`=0 for 3 cycles;
  - then `wb_en` with addr 5, data 0x3331, in the same cycle → `stall`=0, `op_a`=0x3331.
- Same-cycle set/clear: R7 pending; `wb_en` addr 7 coincides with an issue with rd=7 → R7 updated, `pend[7]`=1, and a subsequent read of R7 stalls.
- WAW: R2 pending; offer rd=2 with `dec_writes` → `stall`=1 until `wb_en` addr 2.
- R0 rules:
  - write 0x0034 to R0 → R0 still reads 0;
  - issue rd=0 with `dec_writes` → no `pend` set and no stall for a following read of R0.

Source files
------------

// File: rtl/operand_fetch_block.sv
// Register file + scoreboard operand fetch; bypasses same-cycle write-back results.
// Latency: operands registered 1 cycle after issue; write-back visible via bypass same cycle.
// Backpressure: combinational stall to decode on RAW/WAW hazard; write-back is never stalled.
module operand_fetch_block #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] ans_wb,
    input  logic              dec_valid,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              dec_writes,
    output logic              stall,
    output logic              op_valid,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [ADDR_W-1:0] op_rd
);
    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   pend;
    logic [NREG-1:0]   pend_nxt;

    logic [DATA_W-1:0] rs_dat;
    logic [DATA_W-1:0] rt_dat;
    logic              rs_haz;
    logic              rt_haz;
    logic              waw_haz;
    logic              issue;

    // Source A lookup: R0 is zero, bypass beats the scoreboard, pending means hazard
    always_comb begin
        rs_dat = '0;
        rs_haz = 1'b0;
        if (rs_addr == '0) begin
            rs_dat = '0;
        end else if (wb_en && (wb_addr == rs_addr)) begin
            rs_dat = ans_wb;
        end else if (pend[rs_addr]) begin
            rs_haz = 1'b1;
        end else begin
            rs_dat = regs[rs_addr];
        end
    end

    // Source B lookup: same rules as source A
    always_comb begin
        rt_dat = '0;
        rt_haz = 1'b0;
        if (rt_addr == '0) begin
            rt_dat = '0;
        end else if (wb_en && (wb_addr == rt_addr)) begin
            rt_dat = ans_wb;
        end else if (pend[rt_addr]) begin
            rt_haz = 1'b1;
        end else begin
            rt_dat = regs[rt_addr];
        end
    end

    // Stall decision: a second outstanding write to one register is refused
    // unless the first one retires this very cycle
    always_comb begin
        waw_haz = dec_writes && (rd_addr != '0) && pend[rd_addr]
                  && !(wb_en && (wb_addr == rd_addr));
        stall   = dec_valid && (rs_haz || rt_haz || waw_haz);
        issue   = dec_valid && !stall;
    end

    // Scoreboard next state: clear on write-back first so a same-cycle issue set wins
    always_comb begin
        pend_nxt = pend;
        if (wb_en) begin
            pend_nxt[wb_addr] = 1'b0;
        end
        if (issue && dec_writes && (rd_addr != '0)) begin
            pend_nxt[rd_addr] = 1'b1;
        end
        pend_nxt[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend <= '0;
        end else begin
            pend <= pend_nxt;
        end
    end

    // Register file write port; write-back is never held off by stall, R0 is never written
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en && (wb_addr != '0)) begin
            regs[wb_addr] <= ans_wb;
        end
    end

    // Operand output register: loads on issue, otherwise holds data and drops valid
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_valid <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            op_rd    <= '0;
        end else begin
            op_valid <= issue;
            if (issue) begin
                op_a  <= rs_dat;
                op_b  <= rt_dat;
                op_rd <= rd_addr;
            end
        end
    end
endmodule

// File: tb/tb_operand_fetch_block.sv
// Self-checking bench for operand_fetch_block; scoreboard queue of expected operands.
// Latency: expected entry pushed in the issue cycle, popped one edge later.
// Backpressure: stall is checked against expectations every driven cycle.
module tb_operand_fetch_block;
    logic        clk = 1'b0;
    logic        reset;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [15:0] ans_wb;
    logic        dec_valid;
    logic [3:0]  rs_addr;
    logic [3:0]  rt_addr;
    logic [3:0]  rd_addr;
    logic        dec_writes;
    logic        stall;
    logic        op_valid;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [3:0]  op_rd;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  rd;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks   = 0;
    int          failures = 0;
    logic        mon_en   = 1'b0;
    logic [15:0] last_a   = '0;
    logic [15:0] last_b   = '0;
    logic [3:0]  last_rd  = '0;

    operand_fetch_block #(.DATA_W(16), .ADDR_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .ans_wb     (ans_wb),
        .dec_valid  (dec_valid),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .rd_addr    (rd_addr),
        .dec_writes (dec_writes),
        .stall      (stall),
        .op_valid   (op_valid),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_rd      (op_rd)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Output monitor: op_valid must match the scoreboard; data holds while not valid
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            check_val("op_valid", {31'b0, op_valid}, {31'b0, (exp_q.size() != 0)});
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                if (op_valid) begin
                    check_val("op_a", {16'b0, op_a}, {16'b0, mon_e.a});
                    check_val("op_b", {16'b0, op_b}, {16'b0, mon_e.b});
                    check_val("op_rd", {28'b0, op_rd}, {28'b0, mon_e.rd});
                end
                last_a  = mon_e.a;
                last_b  = mon_e.b;
                last_rd = mon_e.rd;
            end else begin
                check_val("hold_a", {16'b0, op_a}, {16'b0, last_a});
                check_val("hold_b", {16'b0, op_b}, {16'b0, last_b});
                check_val("hold_rd", {28'b0, op_rd}, {28'b0, last_rd});
            end
        end
    end

    // One cycle of stimulus; entered and left at posedge+2
    task automatic cycle_in(input logic dv, input logic [3:0] rs, input logic [3:0] rt,
                            input logic [3:0] rd, input logic dw, input logic we,
                            input logic [3:0] wa, input logic [15:0] wd,
                            input logic es, input logic [15:0] ea, input logic [15:0] eb);
        exp_t e;
        dec_valid  = dv;
        rs_addr    = rs;
        rt_addr    = rt;
        rd_addr    = rd;
        dec_writes = dw;
        wb_en      = we;
        wb_addr    = wa;
        ans_wb     = wd;
        #2;
        check_val("stall", {31'b0, stall}, {31'b0, es});
        if (dv && !es) begin
            e.a  = ea;
            e.b  = eb;
            e.rd = rd;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [3:0]  ri;
        logic [3:0]  rj;
        logic [15:0] vi;
        logic [15:0] vj;

        reset = 1'b1; wb_en = 1'b0; wb_addr = '0; ans_wb = '0;
        dec_valid = 1'b0; rs_addr = '0; rt_addr = '0; rd_addr = '0; dec_writes = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        check_val("rst_op_valid", {31'b0, op_valid}, 32'h0);
        check_val("rst_op_a", {16'b0, op_a}, 32'h0);
        check_val("rst_op_b", {16'b0, op_b}, 32'h0);
        check_val("rst_op_rd", {28'b0, op_rd}, 32'h0);
        check_val("rst_stall", {31'b0, stall}, 32'h0);
        reset  = 1'b0;
        mon_en = 1'b1;

        // Write then read, with R0 on the other source
        cycle_in(0, 0, 0, 0, 0, 1, 3, 16'h1111, 0, 0, 0);
        cycle_in(1, 3, 0, 1, 0, 0, 0, 0, 0, 16'h1111, 16'h0000);

        // RAW: three stalled cycles, then released by same-cycle bypass
        cycle_in(1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle_in(1, 5, 3, 6, 0, 0, 0, 0, 1, 0, 0);
        cycle_in(1, 5, 3, 6, 0, 1, 5, 16'h3331, 0, 16'h3331, 16'h1111);
        cycle_in(1, 5, 5, 4, 0, 0, 0, 0, 0, 16'h3331, 16'h3331);

        // Same-cycle set and clear on R7: set wins, later read stalls
        cycle_in(1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0);
        cycle_in(1, 0, 0, 7, 1, 1, 7, 16'h7777, 0, 0, 0);
        cycle_in(1, 7, 0, 1, 0, 0, 0, 0, 1, 0, 0);
        cycle_in(1, 0, 7, 1, 0, 0, 0, 0, 1, 0, 0);
        cycle_in(1, 0, 7, 1, 0, 1, 7, 16'h7778, 0, 0, 16'h7778);
        cycle_in(1, 7, 3, 1, 0, 0, 0, 0, 0, 16'h7778, 16'h1111);

        // WAW on R2
        cycle_in(1, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0);
        cycle_in(1, 0, 0, 2, 1, 0, 0, 0, 1, 0, 0);
        cycle_in(1, 0, 0, 2, 1, 0, 0, 0, 1, 0, 0);
        cycle_in(1, 0, 0, 2, 1, 1, 2, 16'h2222, 0, 0, 0);
        cycle_in(0, 0, 0, 0, 0, 1, 2, 16'h2223, 0, 0, 0);
        cycle_in(1, 2, 0, 0, 0, 0, 0, 0, 0, 16'h2223, 0);

        // R0 rules: write ignored, no bypass, never pending
        cycle_in(0, 0, 0, 0, 0, 1, 0, 16'h0034, 0, 0, 0);
        cycle_in(1, 0, 0, 3, 0, 1, 0, 16'h0034, 0, 0, 0);
        cycle_in(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        cycle_in(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        cycle_in(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);

        // Write-back to non-pending registers, then back-to-back reads
        for (int i = 8; i < 16; i++) begin
            ri = 4'(i);
            vi = 16'h0A00 + 16'(i);
            cycle_in(0, 0, 0, 0, 0, 1, ri, vi, 0, 0, 0);
        end
        for (int i = 8; i < 16; i++) begin
            ri = 4'(i);
            rj = 4'(23 - i);
            vi = 16'h0A00 + 16'(i);
            vj = 16'h0A00 + 16'(23 - i);
            cycle_in(1, ri, rj, ri, 0, 0, 0, 0, 0, vi, vj);
        end

        // Reset asserted mid-cycle while an instruction is stalled
        cycle_in(1, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0);
        dec_valid = 1'b1; rs_addr = 4'd9; rt_addr = 4'd8; rd_addr = 4'd3; dec_writes = 1'b0;
        wb_en = 1'b0;
        #2;
        check_val("mid_stall", {31'b0, stall}, 32'h1);
        mon_en = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        check_val("mrst_stall", {31'b0, stall}, 32'h0);
        check_val("mrst_op_valid", {31'b0, op_valid}, 32'h0);
        check_val("mrst_op_a", {16'b0, op_a}, 32'h0);
        check_val("mrst_op_b", {16'b0, op_b}, 32'h0);
        @(posedge clk);
        #2;
        reset   = 1'b0;
        last_a  = '0;
        last_b  = '0;
        last_rd = '0;
        mon_en  = 1'b1;
        cycle_in(1, 9, 8, 3, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i < 16; i++) begin
            ri = 4'(i);
            rj = 4'(16 - i);
            cycle_in(1, ri, rj, 1, 0, 0, 0, 0, 0, 0, 0);
        end

        cycle_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_val("q_empty", exp_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
